uart_rx_top: RTL and testbench

// - Top-level UART receiver, 8N1 (1 start, 8 data LSB-first, 1 stop, no parity).
// - Takes asynchronous serial input from the host PC and deserialises it.
// - Presents each received byte on o_RX (drives board LEDs) with a 1-cycle valid strobe.
// - Single clock domain; only the serial input is asynchronous.

---
 rtl/uart_rx_top.sv | 143 ++++++++++++++
 tb/tb_uart_rx_top.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_top.sv
// uart_rx_top: 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop, no parity).
// The serial input passes through a 2-flop synchroniser. A single FSM then
// samples each bit at its middle and presents the byte on o_RX with a
// 1-cycle o_RX_DV strobe.
// Optional feature macro: UART_RX_FRAME_ERR_EN. When it is defined, the
// o_frame_err port is added, and a frame whose stop bit is 0 is rejected.
//
// Output handshake: o_RX_DV is a valid-only strobe with no ready. It is high
// for exactly one i_clk cycle per accepted byte, and o_RX changes only in
// that cycle. The consumer must capture o_RX whenever o_RX_DV is high,
// because there is no back-pressure.
module uart_rx_top #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 9600
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_Rx_serial,
`ifdef UART_RX_FRAME_ERR_EN
   output logic       o_frame_err,
`endif
   output logic       o_RX_DV,
   output logic [7:0] o_RX
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

   // Receiver FSM state. It is kept as a named enum signal so that checkers
   // can bind to it directly.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_CLEANUP = 3'd4
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rx_s;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       idx;
   logic [7:0]       shift_reg;

   // Two-flop synchroniser for the asynchronous line. Both flops reset to
   // idle-high, so reset never looks like a start edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_Rx_serial;
         rx_s    <= rx_meta;
      end
   end

   // Frame decoder: mid-bit sampling, byte assembly and the registered output strobe.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         clk_cnt   <= '0;
         idx       <= 3'd0;
         shift_reg <= 8'h00;
         o_RX      <= 8'h00;
         o_RX_DV   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         o_frame_err <= 1'b0;
`endif
      end else begin
         o_RX_DV <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         o_frame_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               clk_cnt <= '0;
               idx     <= 3'd0;
               if (!rx_s) state <= S_START;
            end
            // Re-check the line at the middle of the start bit. If it has
            // gone high again, the low level was a glitch and is discarded.
            S_START: begin
               if (clk_cnt == CNT_HALF) begin
                  clk_cnt <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            // Each full bit period counted from the mid-start point lands
            // at the middle of the next data bit.
            S_DATA: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt        <= '0;
                  shift_reg[idx] <= rx_s;
                  if (idx == 3'd7) begin
                     idx   <= 3'd0;
                     state <= S_STOP;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            // The byte is delivered at the middle of the stop bit. This lets
            // IDLE catch a start edge that follows immediately.
            S_STOP: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  state   <= S_CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
                  if (rx_s) begin
                     o_RX    <= shift_reg;
                     o_RX_DV <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
`else
                  o_RX    <= shift_reg;
                  o_RX_DV <= 1'b1;
`endif
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            S_CLEANUP: begin
               clk_cnt <= '0;
               state   <= S_IDLE;
            end
            default: begin
               clk_cnt <= '0;
               idx     <= 3'd0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed bench for uart_rx_top with a small bit period
// (16 clocks per bit). Byte frames come from a vector table. Hand-written
// sequences cover glitch, reset mid-frame and stop-bit handling.
module tb_uart_rx_top;

   localparam int CLK_FREQ_HZ = 100_000_000;
   localparam int BAUD_RATE   = 6_250_000;
   localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;   // 16 clocks per bit

   logic       clk;
   logic       rst_n;
   logic       rx_line;
   logic       rx_dv;
   logic [7:0] rx_byte;
`ifdef UART_RX_FRAME_ERR_EN
   logic       frame_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int dv_count = 0;
   int fe_count = 0;
   logic [7:0] exp_q[$];

   uart_rx_top #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_Rx_serial(rx_line),
`ifdef UART_RX_FRAME_ERR_EN
      .o_frame_err(frame_err),
`endif
      .o_RX_DV    (rx_dv),
      .o_RX       (rx_byte)
   );

   // Clock generation: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / monitor (samples on the falling edge) ----------------
   logic       dv_prev = 1'b0;
   logic [7:0] rx_prev = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_dv) begin
            dv_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_dv: got o_RX=%02h, expected no strobe", rx_byte);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rx_byte !== e) begin
                  n_fail++;
                  $display("FAIL rx_byte: got %02h, expected %02h", rx_byte, e);
               end
            end
            n_checks++;
            if (dv_prev) begin
               n_fail++;
               $display("FAIL dv_width: o_RX_DV high %0d, expected 0 on consecutive cycle", 1);
            end
         end
         if (rx_byte !== rx_prev && !rx_dv) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_hold: o_RX changed %02h -> %02h, expected change only with o_RX_DV",
                     rx_prev, rx_byte);
         end
`ifdef UART_RX_FRAME_ERR_EN
         if (frame_err) fe_count++;
`endif
      end
      dv_prev = rx_dv;
      rx_prev = rx_byte;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int start_extra, input logic stop_bit);
      rx_line = 1'b0;
      wait_clks(CPB + start_extra);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         wait_clks(CPB);
      end
      rx_line = stop_bit;
      wait_clks(CPB);
      rx_line = 1'b1;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 400;
      while (exp_q.size() != 0 && budget > 0) begin
         wait_clks(1);
         budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d bytes still pending, expected 0", name, exp_q.size());
      end
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      logic [7:0] data;
      int         start_extra;
      int         gap_clks;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int dv_before;

      vecs[0] = '{data: 8'h56, start_extra: 0, gap_clks: 48, exp_byte: 8'h56};
      vecs[1] = '{data: 8'h56, start_extra: 5, gap_clks: 48, exp_byte: 8'h56};  // stretched start
      vecs[2] = '{data: 8'hA5, start_extra: 0, gap_clks: 0,  exp_byte: 8'hA5};  // back-to-back ...
      vecs[3] = '{data: 8'h3C, start_extra: 0, gap_clks: 48, exp_byte: 8'h3C};  // ... with this one
      vecs[4] = '{data: 8'h00, start_extra: 0, gap_clks: 48, exp_byte: 8'h00};
      vecs[5] = '{data: 8'hFF, start_extra: 0, gap_clks: 48, exp_byte: 8'hFF};
      vecs[6] = '{data: 8'h3C, start_extra: 0, gap_clks: 48, exp_byte: 8'h3C};

      // Reset with the line idle.
      rx_line = 1'b1;
      rst_n   = 1'b0;
      wait_clks(5);
      check8("reset_rx", rx_byte, 8'h00);
      check8("reset_dv", {7'd0, rx_dv}, 8'h00);
      rst_n = 1'b1;
      wait_clks(10);

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(vecs[i].exp_byte);
         send_frame(vecs[i].data, vecs[i].start_extra, 1'b1);
         if (vecs[i].gap_clks > 0) begin
            wait_clks(vecs[i].gap_clks);
            drain($sformatf("vec%0d_drain", i));
         end
      end
      check_int("table_dv_count", dv_count, 7);

      // Glitch: a low pulse shorter than half a bit must be ignored.
      dv_before = dv_count;
      rx_line = 1'b0;
      wait_clks(CPB / 4);
      rx_line = 1'b1;
      wait_clks(3 * CPB);
      check_int("glitch_no_dv", dv_count, dv_before);
      check8("glitch_rx_hold", rx_byte, 8'h3C);

      // Reset during bit 4 of 0xFF: frame aborted, o_RX cleared.
      dv_before = dv_count;
      rx_line = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_line = 1'b1;
         wait_clks(CPB);
      end
      rx_line = 1'b1;
      wait_clks(CPB / 2);
      rst_n = 1'b0;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(CPB * 4 + 5);
      wait_clks(2 * CPB);
      check_int("midreset_no_dv", dv_count, dv_before);
      check8("midreset_rx", rx_byte, 8'h00);

      // Next frame after the aborted one.
      exp_q.push_back(8'h81);
      send_frame(8'h81, 0, 1'b1);
      wait_clks(48);
      drain("after_reset_drain");
      check8("after_reset_rx", rx_byte, 8'h81);

      // Stop bit sampled as 0.
      dv_before = dv_count;
`ifdef UART_RX_FRAME_ERR_EN
      send_frame(8'h5A, 0, 1'b0);
      wait_clks(3 * CPB);
      check_int("ferr_no_dv", dv_count, dv_before);
      check_int("ferr_pulse", fe_count, 1);
      check8("ferr_rx_hold", rx_byte, 8'h81);
`else
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 0, 1'b0);
      wait_clks(3 * CPB);
      drain("bad_stop_drain");
      check_int("bad_stop_dv", dv_count, dv_before + 1);
      check8("bad_stop_rx", rx_byte, 8'h5A);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL timeout: simulation time %0t, expected completion earlier", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
